// File: rtl/fp_minmax_pipe.sv
// Multi-lane IEEE-754 single-precision min/max with RISC-V NaN/signed-zero rules.
// Compare happens in stage 0; remaining LATENCY-1 stages are a stallable delay line.
module fp_minmax_pipe #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned TAG_W   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_op_max,
  input  logic [LANES-1:0]       in_lane_en,
  input  logic [32*LANES-1:0]    in_a,
  input  logic [32*LANES-1:0]    in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*LANES-1:0]    out_q,
  output logic [LANES-1:0]       out_nv,
  output logic [TAG_W-1:0]       out_tag
);

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

  // Sign-magnitude ordering; differing signs puts -0.0 below +0.0.
  function automatic logic less_than(input logic [31:0] x, input logic [31:0] y);
    if (x[31] != y[31]) return x[31];
    if (x[31])          return x[30:0] > y[30:0];
    return x[30:0] < y[30:0];
  endfunction

  function automatic logic [31:0] lane_result(input logic op_max, input logic en,
                                              input logic [31:0] a, input logic [31:0] b);
    logic a_nan;
    logic b_nan;
    a_nan = is_nan(a);
    b_nan = is_nan(b);
    if (!en)                 return '0;
    if (a_nan && b_nan)      return 32'h7FC0_0000;
    if (a_nan)               return b;
    if (b_nan)               return a;
    if (op_max)              return less_than(a, b) ? b : a;
    return less_than(b, a) ? b : a;
  endfunction

  logic                   advance;
  logic [32*LANES-1:0]    res0;
  logic [LANES-1:0]       nv0;

  logic [LATENCY-1:0]     vld_q, vld_d;
  logic [32*LANES-1:0]    res_q [LATENCY];
  logic [32*LANES-1:0]    res_d [LATENCY];
  logic [LANES-1:0]       nv_q  [LATENCY];
  logic [LANES-1:0]       nv_d  [LATENCY];
  logic [TAG_W-1:0]       tag_q [LATENCY];
  logic [TAG_W-1:0]       tag_d [LATENCY];

  assign out_valid = vld_q[LATENCY-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_comb begin
    res0 = '0;
    nv0  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      res0[32*i +: 32] = lane_result(in_op_max, in_lane_en[i], in_a[32*i +: 32], in_b[32*i +: 32]);
      nv0[i]           = in_lane_en[i] && (is_snan(in_a[32*i +: 32]) || is_snan(in_b[32*i +: 32]));
    end
  end

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    nv_d  = nv_q;
    tag_d = tag_q;
    if (advance) begin
      vld_d[0] = in_valid;
      res_d[0] = res0;
      nv_d[0]  = nv0;
      tag_d[0] = in_tag;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        vld_d[s] = vld_q[s-1];
        res_d[s] = res_q[s-1];
        nv_d[s]  = nv_q[s-1];
        tag_d[s] = tag_q[s-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // Payload is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clock) begin
    res_q <= res_d;
    nv_q  <= nv_d;
    tag_q <= tag_d;
  end

  assign out_q   = out_valid ? res_q[LATENCY-1] : '0;
  assign out_nv  = out_valid ? nv_q[LATENCY-1]  : '0;
  assign out_tag = out_valid ? tag_q[LATENCY-1] : '0;

endmodule

// File: tb/tb_fp_minmax_pipe.sv
// Directed bench for fp_minmax_pipe with LANES=4, LATENCY=3.
module tb_fp_minmax_pipe;

  localparam int unsigned LANES   = 4;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned TAG_W   = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic                in_op_max;
  logic [LANES-1:0]    in_lane_en;
  logic [32*LANES-1:0] in_a;
  logic [32*LANES-1:0] in_b;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [32*LANES-1:0] out_q;
  logic [LANES-1:0]    out_nv;
  logic [TAG_W-1:0]    out_tag;

  int checks = 0;
  int errors = 0;

  fp_minmax_pipe #(.LANES(LANES), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op_max(in_op_max),
    .in_lane_en(in_lane_en), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_nv(out_nv), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run_beat(input string name, input logic op, input logic [3:0] en,
                          input logic [127:0] a, input logic [127:0] b, input logic [7:0] tag,
                          input logic [127:0] exp_q, input logic [3:0] exp_nv);
    int unsigned cyc;
    in_valid = 1'b1; in_op_max = op; in_lane_en = en;
    in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
    #1;
    chk({name, "_in_ready"}, 128'(in_ready), 128'd1);
    tick;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 12) begin
      tick;
      cyc++;
    end
    chk({name, "_latency"}, 128'(cyc), 128'd3);
    chk({name, "_valid"}, 128'(out_valid), 128'd1);
    chk({name, "_q"}, out_q, exp_q);
    chk({name, "_nv"}, 128'(out_nv), 128'(exp_nv));
    chk({name, "_tag"}, 128'(out_tag), 128'(tag));
    tick;
    chk({name, "_drain"}, 128'(out_valid), 128'd0);
  endtask

  function automatic logic [127:0] bp_a(input int unsigned k);
    logic [127:0] r;
    for (int unsigned i = 0; i < 4; i++) r[32*i +: 32] = {1'b0, 8'h80, 23'(k*4 + i)};
    return r;
  endfunction

  function automatic logic [127:0] bp_b(input int unsigned k);
    return bp_a(k) | {4{32'h8000_0000}};
  endfunction

  function automatic logic [127:0] bp_exp(input int unsigned k);
    return k[0] ? bp_a(k) : bp_b(k);
  endfunction

  initial begin
    int unsigned  sent;
    int unsigned  rcvd;
    logic         stalled_prev;
    logic [127:0] prev_q;
    logic [7:0]   prev_tag;

    reset = 1'b1; in_valid = 1'b0; in_op_max = 1'b0; in_lane_en = '0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    tick; tick;
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_q", out_q, 128'd0);
    chk("rst_nv", 128'(out_nv), 128'd0);
    chk("rst_tag", 128'(out_tag), 128'd0);
    reset = 1'b0;
    tick;
    chk("idle_valid", 128'(out_valid), 128'd0);
    chk("idle_in_ready", 128'(in_ready), 128'd1);

    // Ordinary min, signed zeros, one qNaN, sNaN+qNaN.
    run_beat("min_mix", 1'b0, 4'b1111,
             {32'h7F800001, 32'h7FC00000, 32'h00000000, 32'h40400000},
             {32'h7FC00000, 32'h40000000, 32'h80000000, 32'hBFC00000}, 8'h5A,
             {32'h7FC00000, 32'h40000000, 32'h80000000, 32'hBFC00000}, 4'b1000);
    // Max: signed zeros, twin sNaN, mixed signs, two negatives.
    run_beat("max_mix", 1'b1, 4'b1111,
             {32'hC0000000, 32'h40400000, 32'h7FA00000, 32'h00000000},
             {32'hBF800000, 32'hBFC00000, 32'h7FA00000, 32'h80000000}, 8'h33,
             {32'hBF800000, 32'h40400000, 32'h7FC00000, 32'h00000000}, 4'b0010);
    // Denormals, negative denormals, infinities, twin qNaN.
    run_beat("min_edge", 1'b0, 4'b1111,
             {32'h7FC00000, 32'hFF800000, 32'h80000001, 32'h00000003},
             {32'h7FC00000, 32'h7F800000, 32'h80000002, 32'h00000002}, 8'hC3,
             {32'h7FC00000, 32'hFF800000, 32'h80000002, 32'h00000002}, 4'b0000);
    // Lanes 1 and 3 disabled, both carrying sNaN.
    run_beat("lane_en", 1'b0, 4'b0101,
             {32'h7F800001, 32'hBF800000, 32'h7F800001, 32'h40000000},
             {32'h12345678, 32'h3F800000, 32'h00000000, 32'h7FC00001}, 8'h77,
             {32'h00000000, 32'hBF800000, 32'h00000000, 32'h40000000}, 4'b0000);

    // Six back-to-back beats with a four-cycle output stall.
    sent = 0; rcvd = 0; stalled_prev = 1'b0; prev_q = '0; prev_tag = '0;
    for (int c = 0; c < 40 && rcvd < 6; c++) begin
      out_ready  = !(c >= 4 && c <= 7);
      in_valid   = (sent < 6);
      in_op_max  = sent[0];
      in_lane_en = '1;
      in_a       = bp_a(sent);
      in_b       = bp_b(sent);
      in_tag     = 8'(sent);
      #1;
      if (stalled_prev) begin
        chk("bp_hold_q", out_q, prev_q);
        chk("bp_hold_tag", 128'(out_tag), 128'(prev_tag));
      end
      if (out_valid && !out_ready) chk("bp_stall_in_ready", 128'(in_ready), 128'd0);
      if (out_valid && out_ready) begin
        chk("bp_tag_order", 128'(out_tag), 128'(8'(rcvd)));
        chk("bp_q", out_q, bp_exp(rcvd));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      stalled_prev = out_valid && !out_ready;
      prev_q = out_q;
      prev_tag = out_tag;
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", 128'(sent), 128'd6);
    chk("bp_rcvd", 128'(rcvd), 128'd6);
    tick;
    chk("bp_no_dup", 128'(out_valid), 128'd0);

    // Reset with two beats held in the pipe.
    out_ready = 1'b0; in_valid = 1'b1; in_op_max = 1'b0; in_lane_en = '1;
    in_a = {4{32'h40400000}}; in_b = {4{32'hBFC00000}}; in_tag = 8'hA1;
    tick;
    in_tag = 8'hA2;
    tick;
    in_valid = 1'b0;
    tick;
    chk("pre_rst_valid", 128'(out_valid), 128'd1);
    chk("pre_rst_tag", 128'(out_tag), 128'hA1);
    chk("pre_rst_q", out_q, {4{32'hBFC00000}});
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_q", out_q, 128'd0);
    chk("mid_rst_nv", 128'(out_nv), 128'd0);
    chk("mid_rst_tag", 128'(out_tag), 128'd0);
    tick; tick;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("post_rst_valid", 128'(out_valid), 128'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
